// File: rtl/mux4_buffer.sv
// mux4_buffer: 4:1 selector built from four tri-state buffers on a pulled-down bus, registered output.
// Build option MUX4_BUFFER_COMB_BYPASS_EN drives y straight from the bus (no register, zero latency).
module mux4_buffer #(
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s1,
   input  logic             s0,
   input  logic [WIDTH-1:0] d3,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d0,
   input  logic             oe,
   output logic [WIDTH-1:0] y,
   output logic             y_valid
);

   logic [3:0] en;

   // Undriven bus (oe=0) resolves to 0 rather than floating.
   tri0 [WIDTH-1:0] bus;

   assign en[0] = oe & ~s1 & ~s0;
   assign en[1] = oe & ~s1 &  s0;
   assign en[2] = oe &  s1 & ~s0;
   assign en[3] = oe &  s1 &  s0;

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      bufif1 u_buf0 (bus[b], d0[b], en[0]);
      bufif1 u_buf1 (bus[b], d1[b], en[1]);
      bufif1 u_buf2 (bus[b], d2[b], en[2]);
      bufif1 u_buf3 (bus[b], d3[b], en[3]);
   end

`ifdef MUX4_BUFFER_COMB_BYPASS_EN
   assign y       = rst_n ? bus : RST_VAL;
   assign y_valid = rst_n & oe;
`else
   logic [WIDTH-1:0] y_q, y_d;
   logic             y_valid_q, y_valid_d;

   assign y_d       = oe ? bus : y_q;
   assign y_valid_d = oe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q       <= RST_VAL;
         y_valid_q <= 1'b0;
      end else begin
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
      end
   end

   assign y       = y_q;
   assign y_valid = y_valid_q;
`endif

endmodule

// File: tb/tb_mux4_buffer.sv
// Self-checking bench for mux4_buffer (WIDTH=8); covers both the registered and the bypass build.
module tb_mux4_buffer;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         s1, s0, oe;
   logic [W-1:0] d0, d1, d2, d3;
   logic [W-1:0] y;
   logic         y_valid;

   int n_vec = 0;
   int n_err = 0;

   logic [W:0]   sb[$];
   logic [W-1:0] model_y;

   mux4_buffer #(.WIDTH(W), .RST_VAL('0)) dut (
      .clk(clk), .rst_n(rst_n), .s1(s1), .s0(s0),
      .d3(d3), .d2(d2), .d1(d1), .d0(d0),
      .oe(oe), .y(y), .y_valid(y_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus, push the expectation, compare when the DUT produces it.
   task automatic apply(input string tag, input logic [1:0] s, input logic [W-1:0] a0,
                        input logic [W-1:0] a1, input logic [W-1:0] a2,
                        input logic [W-1:0] a3, input logic en);
      logic [W-1:0] pick;
      logic [W:0]   e;
      case (s)
         2'd0: pick = a0;
         2'd1: pick = a1;
         2'd2: pick = a2;
         default: pick = a3;
      endcase
      s1 = s[1]; s0 = s[0]; d0 = a0; d1 = a1; d2 = a2; d3 = a3; oe = en;
`ifdef MUX4_BUFFER_COMB_BYPASS_EN
      sb.push_back({en, en ? pick : {W{1'b0}}});
      #1;
      e = sb.pop_front();
      chk({tag, ".y"}, y, e[W-1:0]);
      chk({tag, ".vld"}, {{(W-1){1'b0}}, y_valid}, {{(W-1){1'b0}}, e[W]});
      @(posedge clk); #1;
`else
      if (en) model_y = pick;
      sb.push_back({en, model_y});
      @(posedge clk); #1;
      e = sb.pop_front();
      chk({tag, ".y"}, y, e[W-1:0]);
      chk({tag, ".vld"}, {{(W-1){1'b0}}, y_valid}, {{(W-1){1'b0}}, e[W]});
`endif
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".y"}, y, '0);
      chk({tag, ".vld"}, {{(W-1){1'b0}}, y_valid}, '0);
   endtask

   initial begin
      logic [5:0]   v;
      logic [W-1:0] r0, r1, r2, r3;
      rst_n = 1'b0; s1 = 0; s0 = 0; oe = 0; d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      model_y = '0;
      #3 check_reset("rst_init");
      @(negedge clk) rst_n = 1'b1;

      // Asynchronous reset mid-cycle, then first capture after release.
      apply("pre_rst", 2'd0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
      rst_n = 1'b0;
      #1 check_reset("rst_async");
      @(posedge clk); #1 check_reset("rst_hold");
      sb.delete(); model_y = '0;
      @(negedge clk) rst_n = 1'b1;
      apply("post_rst", 2'd0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1);

      // Sweep {s1,s0,d3,d2,d1,d0} on bit 0, random upper bits.
      for (int i = 0; i < 64; i++) begin
         v  = i[5:0];
         r0 = {7'($urandom), v[0]};
         r1 = {7'($urandom), v[1]};
         r2 = {7'($urandom), v[2]};
         r3 = {7'($urandom), v[3]};
         apply("sweep", v[5:4], r0, r1, r2, r3, 1'b1);
      end

      // Hold with oe low, then recapture.
      apply("hold_cap", 2'd3, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
      for (int i = 0; i < 3; i++)
         apply("hold", 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      apply("hold_rel", 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

      // Unselected inputs carrying X must not reach y.
      apply("iso", 2'd1, 8'hxx, 8'hA5, 8'hxx, 8'hxx, 1'b1);

      // Back-to-back selects.
      for (int i = 0; i < 4; i++)
         apply("b2b", 2'(i), 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);

      // Reset while a capture is pending.
      s1 = 1; s0 = 0; d2 = 8'h5A; oe = 1;
      #2 rst_n = 1'b0;
      #1 check_reset("rst_mid");
      @(posedge clk); #1 check_reset("rst_mid_edge");
      sb.delete(); model_y = '0;
      @(negedge clk) rst_n = 1'b1;
      apply("after_mid", 2'd2, 8'h00, 8'h00, 8'h3C, 8'h00, 1'b1);

      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
